// File: rtl/req_encoder_seq.sv
// req_encoder_seq: sticky request capture, lowest-index encode, valid/ack handshake
module req_encoder_seq #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         vld,
  output logic [N-1:0] pend,
  output logic         busy,
  output logic         ovf
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [N-1:0] c, q, set;
  logic [W-1:0] low;
  always_comb begin
    c = (vld && ack) ? (N'(1) << y) : '0;
    q = pend & ~c;
    set = e ? req : '0;
    low = '0;
    for (int i = N - 1; i >= 0; i--) low = q[i] ? W'(i) : low;
  end
  assign busy = vld | (|pend);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      vld <= 1'b0;
      y <= '0;
      pend <= '0;
      ovf <= 1'b0;
    end else begin
      pend <= q | set;
      ovf <= ovf | (|(set & q));
      if (state == IDLE || ack) begin
        state <= (|q) ? HOLD : IDLE;
        vld <= |q;
        y <= (|q) ? low : y;
      end
    end
endmodule
